motor_ramp_sched: RTL and testbench
===================================

MOTOR_RAMP_SCHED -- requirements
Module: motor_ramp_sched

Interface
REQ-001 SHALL have parameter NCH, default 3, meaning number of motor channels.
REQ-002 SHALL have parameter STEP, default 8'd1, meaning maximum duty change per channel per ramp tick.
REQ-003 SHALL have port clk, input, 1, the single block clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port enable, input, 1, motor enable from the watchdog register.
REQ-006 SHALL have port wdog_trip, input, 1, watchdog-tripped status.
REQ-007 SHALL have port ramp_div, input, 8, ramp tick divisor in clk cycles.
REQ-008 SHALL have port target, input, NCH*8, per-channel target duty (channel i at bits 8i+7:8i).
REQ-009 SHALL have port currentlimit, input, NCH, per-channel overcurrent flags.
REQ-010 SHALL have port duty, output, NCH*8, registered per-channel duty to the PWM generators.
REQ-011 SHALL have port duty_we, output, NCH, one-cycle write strobe per channel when its duty changes.
REQ-012 SHALL have port at_target, output, NCH, registered flag, duty equals target.
REQ-013 SHALL have port busy, output, 1, high while the scheduler is outside IDLE.

Function
REQ-014 SHALL run an 8-bit prescaler that counts 0..ramp_div and emits a one-cycle tick on wrap; ramp_div=0 ticks every cycle.
REQ-015 SHALL implement states IDLE, SVC, KILL; IDLE->SVC on tick; SVC services channel index ch = 0..NCH-1, one channel per cycle; SVC->IDLE after ch=NCH-1.
REQ-016 SHALL, in SVC for channel ch, set duty[ch] to target[ch] if |target-duty| <= STEP, else duty +/- STEP toward target; no wrap below 0 or above 255.
REQ-017 SHALL, when currentlimit[ch] is high during service, forbid increase: duty decreases by STEP (floor 0) regardless of target.
REQ-018 SHALL assert duty_we[ch] for exactly the cycle after duty[ch] is updated, and only if the value changed.
REQ-019 SHALL ignore ticks arriving while not in IDLE (no queuing).
REQ-020 SHALL enter KILL from any state when enable=0 or wdog_trip=1; in KILL all duty=0 next cycle, duty_we asserted once for every channel whose duty was non-zero, prescaler held at 0.
REQ-021 SHALL leave KILL to IDLE only when enable=1 and wdog_trip=0; ramping restarts from duty 0.
REQ-022 SHALL give KILL priority over a simultaneous tick or in-progress service.
REQ-023 SHALL update at_target every cycle from registered duty versus current target.
REQ-024 SHALL treat target changes mid-sweep as applying from the next service of that channel.

Reset
REQ-025 SHALL, on reset, set state=IDLE, prescaler=0, ch=0, duty=0, duty_we=0, busy=0; at_target reflects target==0 from the following cycle.
REQ-026 SHALL let reset override KILL and all other inputs; reset mid-sweep abandons the sweep without strobes.

Structure
REQ-027 SHALL place the state encoding (IDLE, SVC, KILL) and the duty width constant in a shared package, motor_pkg.
REQ-028 SHALL use one sub-module, ramp_step, implementing the combinational saturating step of REQ-016/REQ-017 for one channel.

Verification
REQ-029 SHALL cover: ramp_div=3, STEP=1, enable=1, target0=0x04 -> duty0 reaches 0x04 after 4 ticks (16 cycles), duty_we0 pulses 4 times, at_target0=1 after.
REQ-030 SHALL cover: duty1=0x80, target1=0x10, STEP=0x20 -> sequence 0x60,0x40,0x20,0x10, then no further strobes.
REQ-031 SHALL cover: duty2=0x40, currentlimit2=1, target2=0xC0 -> duty2 falls 0x3F..0x00, never exceeds 0x40.
REQ-032 SHALL cover: all duties 0x80, wdog_trip pulses high mid-sweep -> all duty=0 next cycle, three duty_we strobes, no ramp until wdog_trip=0.
REQ-033 SHALL cover: reset asserted during SVC ch=1 -> duty=0, duty_we=0, busy=0 one cycle later.
REQ-034 SHALL cover: ramp_div=0, NCH=3 -> ticks during SVC ignored; exactly one sweep per 4 cycles.

Source files
------------

// File: rtl/motor_pkg.sv
// motor_pkg: shared scheduler state encoding and duty width for the motor ramp scheduler.
package motor_pkg;
    localparam int DW = 8;
    typedef enum logic [1:0] {IDLE, SVC, KILL} state_e;
endpackage

// File: rtl/ramp_step.sv
// ramp_step: combinational saturating step of one channel's duty toward its target.
module ramp_step
    import motor_pkg::*;
(
    input  logic [DW-1:0] cur_i,
    input  logic [DW-1:0] tgt_i,
    input  logic [DW-1:0] step_i,
    input  logic          climit_i,
    output logic [DW-1:0] nxt_o
);
    logic          up;
    logic [DW-1:0] diff;
    // cur+step cannot overflow: it is only taken when tgt is more than step above cur
    always_comb begin
        up    = tgt_i > cur_i;
        diff  = up ? tgt_i - cur_i : cur_i - tgt_i;
        nxt_o = climit_i ? (cur_i > step_i ? cur_i - step_i : '0)
              : diff <= step_i ? tgt_i
              : up ? cur_i + step_i : cur_i - step_i;
    end
endmodule

// File: rtl/motor_ramp_sched.sv
// motor_ramp_sched: prescaled round-robin duty ramping over NCH motor channels with
// overcurrent ramp-down and an enable/watchdog kill path.
module motor_ramp_sched
    import motor_pkg::*;
#(
    parameter int            NCH  = 3,
    parameter logic [DW-1:0] STEP = 8'd1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              wdog_trip,
    input  logic [7:0]        ramp_div,
    input  logic [NCH*DW-1:0] target,
    input  logic [NCH-1:0]    currentlimit,
    output logic [NCH*DW-1:0] duty,
    output logic [NCH-1:0]    duty_we,
    output logic [NCH-1:0]    at_target,
    output logic              busy
);
    localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
    state_e                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [CW-1:0]          ch_q, ch_d;
    logic [NCH-1:0][DW-1:0] duty_q, duty_d;
    logic [NCH-1:0]         we_q, we_d, at_q;
    logic                   kill, tick, last;
    logic [DW-1:0]          cur, nxt;

    assign kill = !enable || wdog_trip;
    // >= rather than == so lowering ramp_div mid-count never waits for a wrap
    assign tick = cnt_q >= ramp_div;
    assign last = ch_q == CW'(NCH - 1);
    assign cur  = duty_q[ch_q];

    ramp_step u_step (
        .cur_i    (cur),
        .tgt_i    (target[ch_q*DW +: DW]),
        .step_i   (STEP),
        .climit_i (currentlimit[ch_q]),
        .nxt_o    (nxt)
    );

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        duty_d  = duty_q;
        we_d    = '0;
        cnt_d   = (kill || tick) ? '0 : cnt_q + 8'd1;
        if (kill) begin
            state_d = KILL;
            ch_d    = '0;
            duty_d  = '0;
            for (int i = 0; i < NCH; i++) we_d[i] = duty_q[i] != '0;
        end else if (state_q == KILL) begin
            state_d = IDLE;
        end else if (state_q == IDLE) begin
            state_d = tick ? SVC : IDLE;
        end else begin
            duty_d[ch_q] = nxt;
            we_d[ch_q]   = nxt != cur;
            state_d      = last ? IDLE : SVC;
            ch_d         = last ? '0 : ch_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ch_q    <= '0;
            duty_q  <= '0;
            we_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            duty_q  <= duty_d;
            we_q    <= we_d;
        end
    end

    always_ff @(posedge clk)
        for (int i = 0; i < NCH; i++) at_q[i] <= (reset ? '0 : duty_q[i]) == target[i*DW +: DW];

    assign duty      = duty_q;
    assign duty_we   = we_q;
    assign at_target = at_q;
    assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_motor_ramp_sched.sv
// tb_motor_ramp_sched: directed scenarios on a STEP=1 instance (a) and a STEP=0x20 instance (b).
module tb_motor_ramp_sched;
    logic        clk = 1'b0;
    logic        reset, enable, wdog_trip;
    logic [7:0]  ramp_div;
    logic [23:0] target;
    logic [2:0]  currentlimit;
    logic [23:0] duty_a, duty_b;
    logic [2:0]  we_a, we_b, at_a, at_b;
    logic        busy_a, busy_b;
    int          total = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    motor_ramp_sched #(.NCH(3), .STEP(8'd1)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .wdog_trip(wdog_trip), .ramp_div(ramp_div),
        .target(target), .currentlimit(currentlimit), .duty(duty_a), .duty_we(we_a),
        .at_target(at_a), .busy(busy_a)
    );

    motor_ramp_sched #(.NCH(3), .STEP(8'h20)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .wdog_trip(wdog_trip), .ramp_div(ramp_div),
        .target(target), .currentlimit(currentlimit), .duty(duty_b), .duty_we(we_b),
        .at_target(at_b), .busy(busy_b)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; enable = 1'b1; wdog_trip = 1'b0;
        ramp_div = 8'd3; target = '0; currentlimit = '0;
        cyc(2);
        total++; if (duty_a !== 24'h0) $display("FAIL reset_duty: got %h want %h", duty_a, 24'h0); else passed++;
        total++; if (we_a !== 3'b000) $display("FAIL reset_we: got %b want %b", we_a, 3'b000); else passed++;
        total++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b want %b", busy_a, 1'b0); else passed++;
        total++; if (at_a !== 3'b111) $display("FAIL reset_at_target: got %b want %b", at_a, 3'b111); else passed++;
    endtask

    task automatic test_ramp;
        int n0 = 0;
        int nother = 0;
        reset = 1'b0; target = 24'h000004;
        for (int i = 0; i < 24; i++) begin
            cyc(1);
            if (we_a[0]) n0++;
            if (we_a[2:1] != 2'b00) nother++;
        end
        total++; if (n0 !== 4) $display("FAIL ramp_strobes: got %0d want %0d", n0, 4); else passed++;
        total++; if (nother !== 0) $display("FAIL ramp_idle_strobes: got %0d want %0d", nother, 0); else passed++;
        total++; if (duty_a !== 24'h000004) $display("FAIL ramp_duty: got %h want %h", duty_a, 24'h000004); else passed++;
        total++; if (at_a !== 3'b111) $display("FAIL ramp_at_target: got %b want %b", at_a, 3'b111); else passed++;
    endtask

    task automatic test_big_step;
        logic [7:0] seq [4];
        logic [7:0] want [4];
        int n = 0;
        want[0] = 8'h60; want[1] = 8'h40; want[2] = 8'h20; want[3] = 8'h10;
        ramp_div = 8'd0; target = 24'h008004;
        cyc(32);
        total++; if (duty_b[15:8] !== 8'h80) $display("FAIL big_preload: got %h want %h", duty_b[15:8], 8'h80); else passed++;
        target[15:8] = 8'h10;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (we_b[1]) begin
                if (n < 4) seq[n] = duty_b[15:8];
                n++;
            end
        end
        total++; if (n !== 4) $display("FAIL big_strobes: got %0d want %0d", n, 4); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++; if (n < i + 1 || seq[i] !== want[i]) $display("FAIL big_seq%0d: got %h want %h", i, seq[i], want[i]); else passed++;
        end
        total++; if (duty_b[15:8] !== 8'h10) $display("FAIL big_final: got %h want %h", duty_b[15:8], 8'h10); else passed++;
    endtask

    task automatic test_climit;
        int exp_v = 8'h3F;
        int n = 0;
        int bad = 0;
        int over = 0;
        target = 24'h401004;
        cyc(280);
        total++; if (duty_a[23:16] !== 8'h40) $display("FAIL climit_preload: got %h want %h", duty_a[23:16], 8'h40); else passed++;
        currentlimit = 3'b100; target[23:16] = 8'hC0;
        for (int i = 0; i < 300; i++) begin
            cyc(1);
            if (duty_a[23:16] > 8'h40) over++;
            if (we_a[2]) begin
                if (int'(duty_a[23:16]) != exp_v) bad++;
                exp_v--;
                n++;
            end
        end
        total++; if (over !== 0) $display("FAIL climit_exceed: got %0d want %0d", over, 0); else passed++;
        total++; if (bad !== 0) $display("FAIL climit_seq: got %0d want %0d", bad, 0); else passed++;
        total++; if (n !== 64) $display("FAIL climit_strobes: got %0d want %0d", n, 64); else passed++;
        total++; if (duty_a[23:16] !== 8'h00) $display("FAIL climit_final: got %h want %h", duty_a[23:16], 8'h00); else passed++;
        currentlimit = 3'b000; target[23:16] = 8'h00;
    endtask

    task automatic test_kill;
        int strobes = 0;
        int nonzero = 0;
        target = 24'h808080;
        cyc(32);
        total++; if (duty_b !== 24'h808080) $display("FAIL kill_preload: got %h want %h", duty_b, 24'h808080); else passed++;
        for (int i = 0; i < 10 && busy_b !== 1'b1; i++) cyc(1);
        total++; if (busy_b !== 1'b1) $display("FAIL kill_wait_svc: got %b want %b", busy_b, 1'b1); else passed++;
        wdog_trip = 1'b1;
        cyc(1);
        total++; if (duty_b !== 24'h0) $display("FAIL kill_duty: got %h want %h", duty_b, 24'h0); else passed++;
        total++; if (we_b !== 3'b111) $display("FAIL kill_we: got %b want %b", we_b, 3'b111); else passed++;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            if (we_b != 3'b000) strobes++;
            if (duty_b != 24'h0) nonzero++;
        end
        total++; if (strobes + nonzero !== 0) $display("FAIL kill_hold: got %0d want %0d", strobes + nonzero, 0); else passed++;
        total++; if (busy_b !== 1'b1) $display("FAIL kill_busy: got %b want %b", busy_b, 1'b1); else passed++;
        wdog_trip = 1'b0;
        cyc(5);
        total++; if (duty_b !== 24'h202020) $display("FAIL kill_resume: got %h want %h", duty_b, 24'h202020); else passed++;
    endtask

    task automatic test_reset_mid;
        ramp_div = 8'd3;
        for (int i = 0; i < 40 && we_a[0] !== 1'b1; i++) cyc(1);
        total++; if (we_a[0] !== 1'b1) $display("FAIL rstmid_wait: got %b want %b", we_a[0], 1'b1); else passed++;
        reset = 1'b1;
        cyc(1);
        total++; if (duty_a !== 24'h0) $display("FAIL rstmid_duty: got %h want %h", duty_a, 24'h0); else passed++;
        total++; if (we_a !== 3'b000) $display("FAIL rstmid_we: got %b want %b", we_a, 3'b000); else passed++;
        total++; if (busy_a !== 1'b0) $display("FAIL rstmid_busy: got %b want %b", busy_a, 1'b0); else passed++;
    endtask

    task automatic test_back_to_back;
        int n0 = 0;
        int idle = 0;
        ramp_div = 8'd0; target = 24'hFFFFFF;
        cyc(1);
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (we_a[0]) n0++;
            if (!busy_a) idle++;
        end
        total++; if (n0 !== 10) $display("FAIL b2b_sweeps: got %0d want %0d", n0, 10); else passed++;
        total++; if (idle !== 10) $display("FAIL b2b_idle: got %0d want %0d", idle, 10); else passed++;
        total++; if (duty_a[7:0] !== 8'd10) $display("FAIL b2b_duty: got %h want %h", duty_a[7:0], 8'd10); else passed++;
    endtask

    initial begin
        test_reset;
        test_ramp;
        test_big_step;
        test_climit;
        test_kill;
        test_reset_mid;
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
